// File: rtl/seg_display_scheduler_if.sv
// Source taps in, display pins out: the bundle between the CPU debug taps and the
// seven-segment display scheduler.
interface seg_display_scheduler_if #(
   parameter int unsigned N_SRC = 4
);
   logic [N_SRC-1:0]    src_valid;
   logic [13*N_SRC-1:0] src_data;
   logic                auto_mode;
   logic [1:0]          sel;
   logic [3:0]          Anode;
   logic [6:0]          LED_out;
   logic [1:0]          cur_src;
   logic                busy;

   modport master (
      output src_valid, src_data, auto_mode, sel,
      input  Anode, LED_out, cur_src, busy
   );

   modport slave (
      input  src_valid, src_data, auto_mode, sel,
      output Anode, LED_out, cur_src, busy
   );
endinterface

// File: rtl/seg_display_scheduler.sv
// Shares a 4-digit seven-segment display between up to N_SRC 13-bit sources: source
// selection, bit-serial double-dabble BCD conversion and anode time-multiplexing.
module seg_display_scheduler #(
   parameter int unsigned N_SRC        = 4,
   parameter int unsigned REFRESH_BITS = 20,
   parameter int unsigned DWELL_BITS   = 27
) (
   input logic                    clk,
   input logic                    rst_n,
   seg_display_scheduler_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e                  state_q, state_d;
   logic [1:0]              cur_src_q, cur_src_d;
   logic [DWELL_BITS-1:0]   dwell_q, dwell_d;
   logic [REFRESH_BITS-1:0] refresh_q;
   logic [3:0]              count_q, count_d;
   logic [12:0]             shift_q, shift_d;
   logic [12:0]             val_q, val_d;
   logic [12:0]             last_val_q, last_val_d;
   logic [1:0]              cap_src_q, cap_src_d;
   logic [1:0]              last_src_q, last_src_d;
   logic [15:0]             bcd_q, bcd_d;
   logic [15:0]             digits_q, digits_d;
   logic                    disp_ok_q, disp_ok_d;
   logic                    busy_q, busy_d;
   logic [3:0]              anode_q, anode_d;
   logic [6:0]              led_q, led_d;

   logic [3:0]  valid_pad;
   logic [12:0] data_pad [4];
   logic        cur_valid;
   logic [12:0] cur_value;
   logic [1:0]  next_src;
   logic [1:0]  cand;
   logic        found;
   logic        start;
   logic [15:0] adj;
   logic [1:0]  scan;
   logic [3:0]  anode_sel;
   logic [3:0]  nib;

   function automatic logic [6:0] seg_encode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Pad to four slots so a 2-bit index never reaches past the real sources.
   always_comb begin
      valid_pad = '0;
      for (int k = 0; k < 4; k++) data_pad[k] = '0;
      for (int unsigned k = 0; k < N_SRC; k++) begin
         valid_pad[k] = bus.src_valid[k];
         data_pad[k]  = bus.src_data[13*k +: 13];
      end
   end

   assign cur_valid = valid_pad[cur_src_q];
   assign cur_value = data_pad[cur_src_q];

   // Next valid source after the current one, wrapping mod N_SRC; holds if none.
   always_comb begin
      next_src = cur_src_q;
      found    = 1'b0;
      cand     = '0;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         cand = 2'((32'(cur_src_q) + k) % N_SRC);
         if (!found && valid_pad[cand]) begin
            next_src = cand;
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      dwell_d   = bus.auto_mode ? dwell_q + DWELL_BITS'(1) : '0;
      cur_src_d = bus.sel;
      if (bus.auto_mode) begin
         cur_src_d = (dwell_q == '1) ? next_src : cur_src_q;
      end
   end

   assign start = cur_valid &&
                  ((cur_value != last_val_q) || (cur_src_q != last_src_q) || !disp_ok_q);

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      shift_d    = shift_q;
      val_d      = val_q;
      cap_src_d  = cap_src_q;
      last_val_d = last_val_q;
      last_src_d = last_src_q;
      bcd_d      = bcd_q;
      digits_d   = digits_q;
      busy_d     = busy_q;
      // A source that goes away invalidates what is on the display.
      disp_ok_d  = cur_valid ? disp_ok_q : 1'b0;
      adj        = bcd_q;
      for (int i = 0; i < 4; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               busy_d  = 1'b1;
            end
         end
         StLoad: begin
            val_d     = cur_value;
            shift_d   = cur_value;
            cap_src_d = cur_src_q;
            bcd_d     = '0;
            count_d   = 4'd12;
            state_d   = StShift;
         end
         StShift: begin
            {bcd_d, shift_d} = {adj, shift_q} << 1;
            count_d          = count_q - 4'd1;
            if (count_q == 4'd0) state_d = StDone;
         end
         StDone: begin
            digits_d   = bcd_q;
            last_val_d = val_q;
            last_src_d = cap_src_q;
            disp_ok_d  = 1'b1;
            busy_d     = 1'b0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign scan = refresh_q[REFRESH_BITS-1 -: 2];

   // Decode from the next digit value so a finished conversion shows on its own edge.
   always_comb begin
      anode_sel = 4'b1111;
      nib       = 4'hf;
      unique case (scan)
         2'd0: begin anode_sel = 4'b0111; nib = digits_d[15:12]; end
         2'd1: begin anode_sel = 4'b1011; nib = digits_d[11:8];  end
         2'd2: begin anode_sel = 4'b1101; nib = digits_d[7:4];   end
         2'd3: begin anode_sel = 4'b1110; nib = digits_d[3:0];   end
         default: ;
      endcase
      anode_d = anode_sel;
      led_d   = seg_encode(nib);
      if (!cur_valid || !disp_ok_d) begin
         anode_d = 4'b1111;
         led_d   = 7'b1111111;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cur_src_q  <= '0;
         dwell_q    <= '0;
         refresh_q  <= '0;
         count_q    <= '0;
         shift_q    <= '0;
         val_q      <= '0;
         last_val_q <= '0;
         cap_src_q  <= '0;
         last_src_q <= '0;
         bcd_q      <= '0;
         digits_q   <= '0;
         disp_ok_q  <= 1'b0;
         busy_q     <= 1'b0;
         anode_q    <= 4'b1111;
         led_q      <= 7'b1111111;
      end else begin
         state_q    <= state_d;
         cur_src_q  <= cur_src_d;
         dwell_q    <= dwell_d;
         refresh_q  <= refresh_q + REFRESH_BITS'(1);
         count_q    <= count_d;
         shift_q    <= shift_d;
         val_q      <= val_d;
         last_val_q <= last_val_d;
         cap_src_q  <= cap_src_d;
         last_src_q <= last_src_d;
         bcd_q      <= bcd_d;
         digits_q   <= digits_d;
         disp_ok_q  <= disp_ok_d;
         busy_q     <= busy_d;
         anode_q    <= anode_d;
         led_q      <= led_d;
      end
   end

   assign bus.Anode   = anode_q;
   assign bus.LED_out = led_q;
   assign bus.cur_src = cur_src_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Scoreboard bench: stimulus predicts each conversion and queues the expected value;
// a monitor pops on every finished conversion and checks every lit digit against it.
module tb_seg_display_scheduler;
   localparam int unsigned N_SRC        = 4;
   localparam int unsigned REFRESH_BITS = 4;
   localparam int unsigned DWELL_BITS   = 6;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg_display_scheduler_if #(.N_SRC(N_SRC)) bus ();

   seg_display_scheduler #(
      .N_SRC       (N_SRC),
      .REFRESH_BITS(REFRESH_BITS),
      .DWELL_BITS  (DWELL_BITS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int unsigned exp_q[$];

   logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   int pw [4] = '{1000, 100, 10, 1};

   // Reference model state: what the display should hold, from the selection rules.
   logic [12:0] src_val [4];
   logic [3:0]  m_valid;
   int          m_src;
   int          m_last_val;
   int          m_last_src;
   bit          m_ok;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply();
      bus.src_valid = m_valid;
      for (int k = 0; k < 4; k++) bus.src_data[13*k +: 13] = src_val[k];
   endtask

   task automatic expect_conv(output bit started);
      started = 1'b0;
      if (!m_valid[m_src]) begin
         m_ok = 1'b0;
      end else if (int'(src_val[m_src]) != m_last_val || m_src != m_last_src || !m_ok) begin
         exp_q.push_back(src_val[m_src]);
         m_last_val = src_val[m_src];
         m_last_src = m_src;
         m_ok       = 1'b1;
         started    = 1'b1;
      end
   endtask

   task automatic wait_conv();
      int n;
      bit seen_hi;
      bit done;
      n = 0; seen_hi = 1'b0; done = 1'b0;
      while (!done && n < 80) begin
         @(negedge clk);
         n++;
         if (bus.busy) seen_hi = 1'b1;
         else if (seen_hi) done = 1'b1;
      end
      check("conv_complete", done, 1);
      repeat (20) @(negedge clk);
   endtask

   initial begin : monitor
      bit prev_busy;
      int busy_len;
      bit have_disp;
      int disp_val;
      bit prev_lit;
      int prev_pos;
      int pos;
      prev_busy = 0; busy_len = 0; have_disp = 0; disp_val = 0; prev_lit = 0; prev_pos = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_busy = 0; busy_len = 0; have_disp = 0; prev_lit = 0;
         end else begin
            if (bus.busy) busy_len++;
            if (prev_busy && !bus.busy) begin
               check("busy_cycles", busy_len, 15);
               check("pending_expect", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) begin
                  disp_val  = exp_q.pop_front();
                  have_disp = 1;
               end
               busy_len = 0;
            end
            prev_busy = bus.busy;
            if (bus.Anode != 4'hf) begin
               pos = -1;
               for (int i = 0; i < 4; i++) if (bus.Anode == ~(4'b1000 >> i)) pos = i;
               check("anode_onehot", pos >= 0, 1);
               check("lit_without_result", have_disp, 1);
               if (pos >= 0) begin
                  if (prev_lit && pos != prev_pos) check("scan_order", pos, (prev_pos + 1) % 4);
                  if (have_disp) check("segments", bus.LED_out, seg_tab[(disp_val / pw[pos]) % 10]);
                  prev_pos = pos;
                  prev_lit = 1;
               end
            end else begin
               prev_lit = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      bit st;
      bit seen;
      bit dark;
      bit prev_b;
      int cnt;
      int falls;
      int newsel;
      int nxt;
      int prev_cs;
      bus.src_valid = '0; bus.src_data = '0; bus.auto_mode = 1'b0; bus.sel = 2'd0;
      for (int k = 0; k < 4; k++) src_val[k] = '0;
      m_valid = '0; m_src = 0; m_last_val = 0; m_last_src = 0; m_ok = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_anode", bus.Anode, 'hf);
      check("rst_led", bus.LED_out, 'h7f);
      check("rst_cur_src", bus.cur_src, 0);
      check("rst_busy", bus.busy, 0);
      step();
      rst_n = 1'b1;

      // Manual source 1 showing 1234, then the extremes.
      step();
      bus.sel = 2'd1; m_src = 1; m_valid = 4'b0010; src_val[1] = 13'd1234; apply();
      expect_conv(st);
      wait_conv();
      check("cur_src_manual", bus.cur_src, 1);
      step(); src_val[1] = 13'd8191; apply(); expect_conv(st); wait_conv();
      step(); src_val[1] = 13'd0;    apply(); expect_conv(st); wait_conv();

      // Change the value five cycles into a conversion.
      step(); src_val[1] = 13'd42; apply(); expect_conv(st);
      cnt = 0;
      while (!bus.busy && cnt < 40) begin @(negedge clk); cnt++; end
      check("busy_rise", bus.busy, 1);
      repeat (4) @(posedge clk);
      #1;
      src_val[1] = 13'd999; apply(); expect_conv(st);
      cnt = 0; falls = 0; prev_b = 1'b1;
      while (falls < 2 && cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (prev_b && !bus.busy) falls++;
         prev_b = bus.busy;
      end
      check("update_within_31", cnt <= 31, 1);
      repeat (20) @(negedge clk);

      // Random manual-mode traffic: either a new selection or new data on the shown source.
      m_valid = 4'b1111;
      for (int it = 0; it < 12; it++) begin
         step();
         if ($urandom_range(0, 1) == 0) begin
            newsel  = int'($urandom_range(0, 3));
            bus.sel = 2'(newsel);
            m_src   = newsel;
         end else if ($urandom_range(0, 3) != 0) begin
            src_val[m_src] = 13'($urandom_range(0, 8191));
         end
         apply();
         expect_conv(st);
         if (st) wait_conv();
         else repeat (24) @(negedge clk);
         check("cur_src_rand", bus.cur_src, m_src);
      end

      // Auto rotation over sources 0, 1 and 3, starting from source 3.
      step(); bus.sel = 2'd3; m_src = 3; apply(); expect_conv(st);
      if (st) wait_conv();
      else repeat (4) @(negedge clk);
      step();
      src_val[0] = 13'd1; src_val[1] = 13'd2; src_val[2] = 13'd7; src_val[3] = 13'd4;
      m_valid = 4'b1011; bus.auto_mode = 1'b1; apply();
      expect_conv(st);
      prev_cs = bus.cur_src;
      for (int w = 0; w < 4; w++) begin
         nxt = m_src;
         for (int k = 4; k >= 1; k--) if (m_valid[(m_src + k) % 4]) nxt = (m_src + k) % 4;
         m_src = nxt;
         expect_conv(st);
         cnt = 0;
         while (bus.cur_src == 2'(prev_cs) && cnt < 200) begin @(negedge clk); cnt++; end
         check("auto_cur_src", bus.cur_src, nxt);
         if (w > 0) check("dwell_interval", cnt, 64);
         prev_cs = bus.cur_src;
      end
      wait_conv();

      // No valid source: dark display.
      step();
      bus.auto_mode = 1'b0; bus.sel = 2'd0; m_src = 0; m_valid = 4'b0000; apply();
      expect_conv(st);
      @(posedge clk);
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         check("blank_anode", bus.Anode, 'hf);
         check("blank_led", bus.LED_out, 'h7f);
      end

      // Source 0 returns: stays dark until its conversion finishes.
      step(); m_valid = 4'b0001; apply(); expect_conv(st);
      cnt = 0; dark = 1'b1; seen = 1'b0;
      while (!(seen && !bus.busy) && cnt < 60) begin
         @(negedge clk);
         cnt++;
         if (bus.busy) seen = 1'b1;
         if (bus.busy && bus.Anode != 4'hf) dark = 1'b0;
      end
      check("dark_during_conv", dark, 1);
      repeat (20) @(negedge clk);
      check("lit_after_conv", bus.Anode != 4'hf, 1);

      // Reset in SHIFT cycle 7 aborts; release restarts from LOAD.
      step(); src_val[0] = 13'd5555; apply();
      repeat (8) @(posedge clk);
      #1;
      check("busy_before_abort", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_anode", bus.Anode, 'hf);
      check("abort_led", bus.LED_out, 'h7f);
      check("abort_cur_src", bus.cur_src, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_last_val = 0; m_last_src = 0; m_ok = 1'b0;
      expect_conv(st);
      wait_conv();

      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
